xm_mem_bridge: RTL and testbench
================================

// Module: xm_mem_bridge
// PURPOSE
//  Multi-cycle memory bus bridge sitting directly downstream of xm_datapath.
//  Accepts one access (MAR word address, OMDR write data, lane select) per start
//  pulse from the controller, runs a req/ack handshake on the external memory bus
//  with timeout, steers/extracts byte lanes, and returns aligned read data (mem_i).
// PARAMETERS
//  WORD      16  data width in bits
//  ADDR_W    15  word address width (matches datapath MAR width WORD-(WORD/8)+1)
//  TIMEOUT   15  max cycles req may stay high without ack before error (>=1)
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       reset, synchronous, active-low
//  start_i      in   1       request one access (sampled only in IDLE)
//  wr_i         in   1       1 = write, 0 = read (sampled with start_i)
//  datSel_i     in   2       lanes: 01 low byte, 10 high byte, 11 word, 00 illegal
//  badMem_i     in   1       address decoder fault flag (sampled with start_i)
//  addr_i       in   ADDR_W  word address (datapath MAR)
//  wdata_i      in   WORD    write data (datapath OMDR); byte data in [7:0]
//  rdata_o      out  WORD    aligned read data to datapath mem_i
//  busy_o       out  1       access in progress
//  done_o       out  1       1-cycle pulse: access completed OK
//  err_o        out  1       1-cycle pulse: access aborted
//  errCode_o    out  2       00 none, 01 badMem, 10 illegal datSel, 11 timeout
//  bus_req_o    out  1       bus request, held until ack or timeout
//  bus_we_o     out  1       bus write enable
//  bus_be_o     out  2       byte enables {hi,lo}
//  bus_addr_o   out  ADDR_W  bus word address
//  bus_wdata_o  out  WORD    bus write data
//  bus_ack_i    in   1       bus acknowledge (1 cycle); rdata valid same cycle
//  bus_rdata_i  in   WORD    bus read data
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): state IDLE; all outputs 0, incl. rdata_o, errCode_o.
//  Reset mid-access drops bus_req_o next edge; no done_o/err_o emitted.
//  FSM: IDLE, REQ, DONE, ERR.
//   IDLE: start_i=1 -> capture wr/datSel/addr/wdata.
//         badMem_i=1 -> ERR, code 01 (priority over datSel check); no bus cycle.
//         datSel_i=00 -> ERR, code 10; no bus cycle. else -> REQ, counter=0.
//   REQ : bus_req_o=1, bus fields stable from captured values for whole state.
//         bus_ack_i=1 -> DONE; read: latch extracted rdata into rdata_o.
//         else counter++; counter==TIMEOUT-1 with no ack -> ERR, code 11.
//         ack and timeout same cycle: ack wins.
//   DONE: done_o=1 one cycle -> IDLE.  ERR: err_o=1 one cycle -> IDLE.
//  Latency: start at edge N -> bus_req_o high after N; ack sampled at edge M ->
//   done_o high after M, bus_req_o low after M. Best case start->done = 2 cycles.
//  busy_o=1 in REQ, DONE, ERR; start_i ignored unless IDLE (no queueing).
//  bus_ack_i outside REQ ignored. errCode_o holds until next start is accepted.
//  Lane rules: write 01 -> be=01, 10 -> be=10, data {wdata[7:0],wdata[7:0]};
//   11 -> be=11, data=wdata. Read 01 -> {8'h00,rdata[7:0]};
//   10 -> {8'h00,rdata[15:8]}; 11 -> rdata unchanged. Zero-extend, no sign ext.
//  rdata_o updates only on successful read; writes and errors leave it unchanged.
//  Outside REQ: bus_we_o=0, bus_be_o=0; addr/wdata hold last value.
// STRUCTURE
//  xm_pkg: typedef enum state_t {IDLE,REQ,DONE,ERR}; datSel and errCode
//   localparams (DS_LO/DS_HI/DS_WORD, ERR_NONE/BADMEM/DSEL/TIMEOUT).
//  Sub-module xm_byte_lane: combinational lane steer (write) and extract (read),
//   reused by datapath byte ops; FSM, counter and capture regs stay in top.
// TESTING
//  1 Word read: start, addr=15'h0100, datSel=11; ack 3 cycles later with 16'hBEEF
//    -> req held 3 cycles, be=11, done_o 1 cycle, rdata_o=16'hBEEF.
//  2 High byte read, rdata=16'hA55A -> rdata_o=16'h00A5; low byte -> 16'h005A.
//  3 Byte write datSel=10, wdata=16'h1234 -> we=1, be=10, bus_wdata=16'h3434;
//    rdata_o unchanged.
//  4 No ack, TIMEOUT=15 -> req low after 15 cycles, err_o pulse, errCode=11;
//    ack on exactly the last cycle instead -> done_o, no err.
//  5 start with badMem_i=1 and datSel=00 -> no req ever, err_o, errCode=01;
//    datSel=00 alone -> errCode=10.
//  6 start during REQ ignored (one access only); rst_ni=0 mid-REQ -> req low
//    next edge, no done/err, all outputs 0.

Source files
------------

// File: rtl/xm_pkg.sv
// Shared types and encodings for the xm memory bridge.
// FSM state enum, lane-select and error-code constants.
package xm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADMEM  = 2'b01;
  localparam logic [1:0] ERR_DSEL    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/xm_byte_lane.sv
// Combinational byte-lane steer (write) and extract (read).
// Ports: dsel_i lane select, wdata_i/rdata_i raw, be_o/wdata_o/rdata_o steered.
module xm_byte_lane
  import xm_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic [1:0]      dsel_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [WORD-1:0] rdata_i,
  output logic [1:0]      be_o,
  output logic [WORD-1:0] wdata_o,
  output logic [WORD-1:0] rdata_o
);

  always_comb begin
    be_o    = 2'b00;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (1'b1)
      (dsel_i == DS_LO): begin
        be_o    = 2'b01;
        wdata_o = {(WORD/8){wdata_i[7:0]}};
        rdata_o = {{(WORD-8){1'b0}}, rdata_i[7:0]};
      end
      (dsel_i == DS_HI): begin
        be_o    = 2'b10;
        wdata_o = {(WORD/8){wdata_i[7:0]}};
        rdata_o = {{(WORD-8){1'b0}}, rdata_i[WORD-1:WORD-8]};
      end
      (dsel_i == DS_WORD): begin
        be_o = 2'b11;
      end
      default: begin
        be_o = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/xm_mem_bridge.sv
// Multi-cycle memory bus bridge: one access per start, req/ack with timeout.
// Ports: start/wr/datSel/badMem/addr/wdata in; rdata/busy/done/err/errCode out; bus_* side.
module xm_mem_bridge
  import xm_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [1:0]        datSel_i,
  input  logic              badMem_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD-1:0]   wdata_i,
  output logic [WORD-1:0]   rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        errCode_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [1:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [WORD-1:0]   bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [WORD-1:0]   bus_rdata_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        ecode_q, ecode_d;
  logic              wr_q;
  logic [1:0]        dsel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD-1:0]   wdata_q;
  logic [WORD-1:0]   rdata_q;
  logic              cap;
  logic              rd_ld;
  logic [1:0]        be;
  logic [WORD-1:0]   wsteer;
  logic [WORD-1:0]   rext;

  xm_byte_lane #(.WORD(WORD)) u_lane (
    .dsel_i  (dsel_q),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata_i),
    .be_o    (be),
    .wdata_o (wsteer),
    .rdata_o (rext)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecode_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecode_q <= ecode_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= 1'b0;
      dsel_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (cap) begin
        wr_q    <= wr_i;
        dsel_q  <= datSel_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (rd_ld) begin
        rdata_q <= rext;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ecode_d   = ecode_q;
    cap       = 1'b0;
    rd_ld     = 1'b0;
    bus_req_o = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cap   = 1'b1;
          cnt_d = '0;
          if (badMem_i) begin
            ecode_d = ERR_BADMEM;
            state_d = ERR;
          end else if (datSel_i == 2'b00) begin
            ecode_d = ERR_DSEL;
            state_d = ERR;
          end else begin
            ecode_d = ERR_NONE;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        bus_req_o = 1'b1;
        // ack on the final allowed cycle still completes
        if (bus_ack_i) begin
          rd_ld   = !wr_q;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          ecode_d = ERR_TIMEOUT;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign errCode_o   = ecode_q;
  assign rdata_o     = rdata_q;
  assign bus_we_o    = bus_req_o & wr_q;
  assign bus_be_o    = bus_req_o ? be : 2'b00;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wsteer;

endmodule

// File: tb/tb_xm_mem_bridge.sv
// Directed scoreboard bench for xm_mem_bridge.
// Completions are pushed at stimulus time and popped on done_o/err_o.
module tb_xm_mem_bridge;
  import xm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  dsel = 2'b00;
  logic        bad = 1'b0;
  logic [14:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        ack = 1'b0;
  logic [15:0] brd = '0;

  logic [15:0] rdata_o;
  logic        busy_o, done_o, err_o;
  logic [1:0]  errCode_o;
  logic        bus_req_o, bus_we_o;
  logic [1:0]  bus_be_o;
  logic [14:0] bus_addr_o;
  logic [15:0] bus_wdata_o;

  xm_mem_bridge #(.WORD(16), .ADDR_W(15), .TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .wr_i        (wr),
    .datSel_i    (dsel),
    .badMem_i    (bad),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .errCode_o   (errCode_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_be_o    (bus_be_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (ack),
    .bus_rdata_i (brd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_rd = '0;
  int          nreq;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit e, input logic [1:0] c, input logic [15:0] r);
    exp_t x;
    x.is_err = e;
    x.code = c;
    x.rd = r;
    sb.push_back(x);
  endtask

  task automatic go(input bit w, input logic [1:0] ds, input bit b,
                    input logic [14:0] a, input logic [15:0] wd);
    start = 1'b1;
    wr = w;
    dsel = ds;
    bad = b;
    addr = a;
    wdata = wd;
    tick();
    start = 1'b0;
    bad = 1'b0;
  endtask

  // counts REQ cycles; ack_at=0 never acks
  task automatic do_req(input int ack_at, input logic [15:0] rd,
                        output int n);
    bit acked;
    acked = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && bus_req_o && !acked; i++) begin
      n++;
      if (n == ack_at) begin
        ack = 1'b1;
        brd = rd;
        acked = 1'b1;
      end
      tick();
      ack = 1'b0;
    end
  endtask

  function automatic logic [15:0] ext(input logic [1:0] ds,
                                      input logic [15:0] r);
    case (ds)
      2'b01:   return {8'h00, r[7:0]};
      2'b10:   return {8'h00, r[15:8]};
      default: return r;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_o || err_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done_o, err_o}, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_done", {31'd0, done_o}, {31'd0, !x.is_err});
        chk("sb_err", {31'd0, err_o}, {31'd0, x.is_err});
        chk("sb_code", {30'd0, errCode_o}, {30'd0, x.code});
        chk("sb_rdata", {16'd0, rdata_o}, {16'd0, x.rd});
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_o}, 32'd0);
    chk("rst_code", {30'd0, errCode_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // word read, ack on third REQ cycle
    exp_rd = ext(2'b11, 16'hBEEF);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b11, 1'b0, 15'h0100, 16'h0);
    chk("t1_be", {30'd0, bus_be_o}, 32'd3);
    chk("t1_we", {31'd0, bus_we_o}, 32'd0);
    chk("t1_addr", {17'd0, bus_addr_o}, 32'h0100);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    do_req(3, 16'hBEEF, nreq);
    chk("t1_nreq", nreq, 32'd3);
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_reqlow", {31'd0, bus_req_o}, 32'd0);
    tick();

    // high byte, then low byte, best-case latency
    exp_rd = ext(2'b10, 16'hA55A);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b10, 1'b0, 15'h0101, 16'h0);
    chk("t2_be_hi", {30'd0, bus_be_o}, 32'd2);
    do_req(1, 16'hA55A, nreq);
    chk("t2_rd_hi", {16'd0, rdata_o}, 32'h00A5);
    tick();
    exp_rd = ext(2'b01, 16'hA55A);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b01, 1'b0, 15'h0102, 16'h0);
    do_req(1, 16'hA55A, nreq);
    chk("t2_rd_lo", {16'd0, rdata_o}, 32'h005A);
    tick();

    // ack while idle must be ignored
    ack = 1'b1;
    brd = 16'hFFFF;
    tick();
    ack = 1'b0;
    tick();
    chk("idle_ack", {16'd0, rdata_o}, {16'd0, exp_rd});

    // byte write to high lane
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b1, 2'b10, 1'b0, 15'h0200, 16'h1234);
    chk("t3_we", {31'd0, bus_we_o}, 32'd1);
    chk("t3_be", {30'd0, bus_be_o}, 32'd2);
    chk("t3_wdata", {16'd0, bus_wdata_o}, 32'h3434);
    do_req(2, 16'h9999, nreq);
    chk("t3_we_off", {31'd0, bus_we_o}, 32'd0);
    chk("t3_be_off", {30'd0, bus_be_o}, 32'd0);
    tick();

    // word write
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b1, 2'b11, 1'b0, 15'h0201, 16'hCAFE);
    chk("t3w_wdata", {16'd0, bus_wdata_o}, 32'hCAFE);
    do_req(1, 16'h0, nreq);
    tick();

    // timeout
    push(1'b1, ERR_TIMEOUT, exp_rd);
    go(1'b0, 2'b11, 1'b0, 15'h0300, 16'h0);
    do_req(0, 16'h0, nreq);
    chk("t4_nreq", nreq, 32'd15);
    chk("t4_err", {31'd0, err_o}, 32'd1);
    chk("t4_code", {30'd0, errCode_o}, 32'd3);
    tick();
    chk("t4_hold", {30'd0, errCode_o}, 32'd3);

    // ack on the last allowed cycle
    exp_rd = ext(2'b11, 16'h0F0F);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b11, 1'b0, 15'h0301, 16'h0);
    do_req(15, 16'h0F0F, nreq);
    chk("t4b_nreq", nreq, 32'd15);
    chk("t4b_done", {31'd0, done_o}, 32'd1);
    chk("t4b_err", {31'd0, err_o}, 32'd0);
    tick();

    // badMem wins over illegal datSel
    push(1'b1, ERR_BADMEM, exp_rd);
    go(1'b0, 2'b00, 1'b1, 15'h0400, 16'h0);
    chk("t5_req", {31'd0, bus_req_o}, 32'd0);
    chk("t5_code", {30'd0, errCode_o}, 32'd1);
    tick();
    chk("t5_req2", {31'd0, bus_req_o}, 32'd0);
    push(1'b1, ERR_DSEL, exp_rd);
    go(1'b0, 2'b00, 1'b0, 15'h0401, 16'h0);
    chk("t5b_req", {31'd0, bus_req_o}, 32'd0);
    tick();
    tick();
    chk("t5b_hold", {30'd0, errCode_o}, 32'd2);

    // start during REQ ignored
    exp_rd = ext(2'b11, 16'hC0DE);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b11, 1'b0, 15'h0500, 16'h0);
    chk("t6_code_clr", {30'd0, errCode_o}, 32'd0);
    tick();
    go(1'b1, 2'b01, 1'b0, 15'h7FFF, 16'h5555);
    chk("t6_addr", {17'd0, bus_addr_o}, 32'h0500);
    chk("t6_we", {31'd0, bus_we_o}, 32'd0);
    do_req(1, 16'hC0DE, nreq);
    chk("t6_done", {31'd0, done_o}, 32'd1);
    tick();
    tick();
    chk("t6_idle", {31'd0, bus_req_o}, 32'd0);

    // reset mid-REQ
    go(1'b1, 2'b11, 1'b0, 15'h0600, 16'hABCD);
    chk("t6r_req", {31'd0, bus_req_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6r_req0", {31'd0, bus_req_o}, 32'd0);
    chk("t6r_busy", {31'd0, busy_o}, 32'd0);
    chk("t6r_rd", {16'd0, rdata_o}, 32'd0);
    chk("t6r_addr", {17'd0, bus_addr_o}, 32'd0);
    chk("t6r_wd", {16'd0, bus_wdata_o}, 32'd0);
    chk("t6r_pulse", {30'd0, done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    exp_rd = '0;
    tick();
    tick();

    // clean access after reset
    exp_rd = ext(2'b01, 16'h77AB);
    push(1'b0, ERR_NONE, exp_rd);
    go(1'b0, 2'b01, 1'b0, 15'h0700, 16'h0);
    do_req(2, 16'h77AB, nreq);
    tick();
    tick();
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
